// File: rtl/light_mode_if.sv
// light_mode_if
//   Pulse, sensor and lamp signals shared between the light mode sequencer
//   and the logic that drives it.
//
//   Signals:
//     A           long-press pulse, one cycle wide (mode toggle request)
//     B           short-press pulse, one cycle wide (lamp toggle request)
//     presenca    presence sensor level, synchronous to the sequencer clock
//     lampada     lamp drive, 1 = on
//     modo_manual 1 while the sequencer is in manual mode
//
//   Modports:
//     master  drives A/B/presenca, observes lampada/modo_manual
//     slave   the sequencer side
interface light_mode_if;
   logic A;
   logic B;
   logic presenca;
   logic lampada;
   logic modo_manual;

   modport master (output A, B, presenca, input lampada, modo_manual);
   modport slave  (input A, B, presenca, output lampada, modo_manual);
endinterface

// File: rtl/light_mode_controller.sv
// light_mode_controller
//   Mode and lamp sequencer for the automatic lighting system.
//   Auto mode: lamp follows presence, held on for OFF_DELAY cycles after
//   presence drops. Manual mode: lamp toggled by short presses (B).
//   A long press (A) switches between the modes without changing the lamp.
//
//   Optional feature (compile-time macro MANUAL_TIMEOUT_EN):
//     when defined, manual mode reverts to auto after MANUAL_TIMEOUT idle
//     cycles (no A/B); when undefined, no idle counter exists and manual
//     mode persists until A or rst.
//
//   Parameters:
//     OFF_DELAY       hold-off cycles in auto mode (>= 1)
//     MANUAL_TIMEOUT  idle cycles before manual reverts (>= 1)
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   light_mode_if.slave (A, B, presenca in; lampada, modo_manual out)
module light_mode_controller #(
   parameter int OFF_DELAY      = 30000,
   parameter int MANUAL_TIMEOUT = 60000
) (
   input  logic        clk,
   input  logic        rst,
   light_mode_if.slave bus
);

   typedef enum logic [2:0] {
      AUTO_OFF  = 3'd0,
      AUTO_ON   = 3'd1,
      AUTO_HOLD = 3'd2,
      MAN_OFF   = 3'd3,
      MAN_ON    = 3'd4
   } state_t;

   localparam int                HOLD_W    = $clog2(OFF_DELAY + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OFF_DELAY - 1);

   if (OFF_DELAY < 1) begin : g_bad_off_delay
      $error("OFF_DELAY must be >= 1");
   end
   if (MANUAL_TIMEOUT < 1) begin : g_bad_manual_timeout
      $error("MANUAL_TIMEOUT must be >= 1");
   end

   state_t            state_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;

`ifdef MANUAL_TIMEOUT_EN
   localparam int                IDLE_W    = $clog2(MANUAL_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(MANUAL_TIMEOUT - 1);
   logic [IDLE_W-1:0] idle_cnt_reg;
`endif

   // Leaving manual mode (A or idle timeout) lands in the auto state that
   // matches the current presence level.
   state_t leave_manual;
   assign leave_manual = bus.presenca ? AUTO_ON : AUTO_OFF;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= AUTO_OFF;
         hold_cnt_reg <= '0;
`ifdef MANUAL_TIMEOUT_EN
         idle_cnt_reg <= '0;
`endif
      end else begin
         // Counters default to zero and only advance while their owning
         // state stays put, so every exit (and every entry) clears them.
         hold_cnt_reg <= '0;
`ifdef MANUAL_TIMEOUT_EN
         idle_cnt_reg <= '0;
`endif
         case (state_reg)
            AUTO_OFF: begin
               if (bus.A)             state_reg <= MAN_OFF;
               else if (bus.presenca) state_reg <= AUTO_ON;
            end
            AUTO_ON: begin
               if (bus.A)              state_reg <= MAN_ON;
               else if (!bus.presenca) state_reg <= AUTO_HOLD;
            end
            AUTO_HOLD: begin
               if (bus.A)                       state_reg <= MAN_ON;
               else if (bus.presenca)           state_reg <= AUTO_ON;
               else if (hold_cnt_reg == HOLD_LAST) state_reg <= AUTO_OFF;
               else                             hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
            MAN_OFF, MAN_ON: begin
               if (bus.A)      state_reg <= leave_manual;
               else if (bus.B) state_reg <= (state_reg == MAN_OFF) ? MAN_ON : MAN_OFF;
`ifdef MANUAL_TIMEOUT_EN
               else if (idle_cnt_reg == IDLE_LAST) state_reg <= leave_manual;
               else            idle_cnt_reg <= idle_cnt_reg + 1'b1;
`endif
            end
            default: state_reg <= AUTO_OFF;
         endcase
      end
   end

   // Moore decode of the state register; reset forces both low at once.
   assign bus.lampada     = (state_reg == AUTO_ON) || (state_reg == AUTO_HOLD) ||
                            (state_reg == MAN_ON);
   assign bus.modo_manual = (state_reg == MAN_OFF) || (state_reg == MAN_ON);

endmodule

// File: tb/tb_light_mode_controller.sv
// tb_light_mode_controller
//   Directed-vector bench for light_mode_controller with OFF_DELAY=4 and
//   MANUAL_TIMEOUT=10. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so every sample reflects the
//   state after the edge just taken.
module tb_light_mode_controller;
   localparam int OFF_DELAY      = 4;
   localparam int MANUAL_TIMEOUT = 10;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   light_mode_if bus ();

   light_mode_controller #(
      .OFF_DELAY      (OFF_DELAY),
      .MANUAL_TIMEOUT (MANUAL_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, leaving time just after the last edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.A = 1'b0; bus.B = 1'b0; bus.presenca = 1'b1;
      tick(2);
      checks++;
      if (bus.lampada !== 1'b0) begin
         errors++; $display("FAIL reset_lamp: got %b want 0", bus.lampada);
      end
      checks++;
      if (bus.modo_manual !== 1'b0) begin
         errors++; $display("FAIL reset_mode: got %b want 0", bus.modo_manual);
      end
      rst = 1'b0;
      tick(1);
      checks++;
      if (bus.lampada !== 1'b1) begin
         errors++; $display("FAIL reset_release_lamp: got %b want 1", bus.lampada);
      end
      checks++;
      if (bus.modo_manual !== 1'b0) begin
         errors++; $display("FAIL reset_release_mode: got %b want 0", bus.modo_manual);
      end
      $display("txn reset: lampada=%b modo_manual=%b", bus.lampada, bus.modo_manual);
   endtask

   task automatic test_hold_off();
      // Entered in AUTO_ON with presence high. Edge k samples presence low.
      bus.presenca = 1'b0;
      for (int e = 0; e <= OFF_DELAY; e++) begin
         logic want;
         tick(1);
         want = (e < OFF_DELAY) ? 1'b1 : 1'b0;
         checks++;
         if (bus.lampada !== want) begin
            errors++; $display("FAIL hold_edge_k+%0d: got %b want %b", e, bus.lampada, want);
         end
      end
      $display("txn hold_off: lamp dropped after edge k+%0d", OFF_DELAY);
      bus.presenca = 1'b1;
      tick(1);
      checks++;
      if (bus.lampada !== 1'b1) begin
         errors++; $display("FAIL hold_rise: got %b want 1", bus.lampada);
      end
      // Presence back high, sampled at edge k+2: lamp must never drop.
      bus.presenca = 1'b0;
      tick(2);
      bus.presenca = 1'b1;
      for (int e = 2; e < 10; e++) begin
         tick(1);
         checks++;
         if (bus.lampada !== 1'b1) begin
            errors++; $display("FAIL hold_return_edge_k+%0d: got %b want 1", e, bus.lampada);
         end
      end
      $display("txn hold_return: lampada=%b", bus.lampada);
   endtask

   task automatic test_mode_switch();
      // AUTO_ON, presence high.
      bus.A = 1'b1; tick(1); bus.A = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b11) begin
         errors++; $display("FAIL sw_to_manual: got %b%b want 11", bus.modo_manual, bus.lampada);
      end
      bus.B = 1'b1; tick(1); bus.B = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b10) begin
         errors++; $display("FAIL sw_b_off: got %b%b want 10", bus.modo_manual, bus.lampada);
      end
      bus.B = 1'b1; tick(1); bus.B = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b11) begin
         errors++; $display("FAIL sw_b_on: got %b%b want 11", bus.modo_manual, bus.lampada);
      end
      bus.presenca = 1'b0;
      bus.A = 1'b1; tick(1); bus.A = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b00) begin
         errors++; $display("FAIL sw_to_auto_off: got %b%b want 00", bus.modo_manual, bus.lampada);
      end
      tick(2);
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b00) begin
         errors++; $display("FAIL sw_auto_off_stays: got %b%b want 00", bus.modo_manual, bus.lampada);
      end
      $display("txn mode_switch: modo_manual=%b lampada=%b", bus.modo_manual, bus.lampada);
   endtask

   task automatic test_simultaneous();
      // AUTO_OFF, presence low.
      bus.A = 1'b1; tick(1); bus.A = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b10) begin
         errors++; $display("FAIL sim_enter_man_off: got %b%b want 10", bus.modo_manual, bus.lampada);
      end
      bus.A = 1'b1; bus.B = 1'b1; tick(1); bus.A = 1'b0; bus.B = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b00) begin
         errors++; $display("FAIL sim_ab: got %b%b want 00", bus.modo_manual, bus.lampada);
      end
      bus.B = 1'b1; tick(1); bus.B = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b00) begin
         errors++; $display("FAIL sim_b_in_auto: got %b%b want 00", bus.modo_manual, bus.lampada);
      end
      $display("txn simultaneous: modo_manual=%b lampada=%b", bus.modo_manual, bus.lampada);
   endtask

   task automatic test_manual_timeout();
      bus.presenca = 1'b1; tick(1);
      bus.A = 1'b1; tick(1); bus.A = 1'b0;   // entry edge into MAN_ON
`ifdef MANUAL_TIMEOUT_EN
      for (int e = 1; e <= MANUAL_TIMEOUT; e++) begin
         logic want;
         tick(1);
         want = (e < MANUAL_TIMEOUT) ? 1'b1 : 1'b0;
         checks++;
         if (bus.modo_manual !== want) begin
            errors++; $display("FAIL to_edge_%0d: got %b want %b", e, bus.modo_manual, want);
         end
      end
      checks++;
      if (bus.lampada !== 1'b1) begin
         errors++; $display("FAIL to_exit_lamp: got %b want 1", bus.lampada);
      end
      // Re-enter, B at edge 6 restarts the count.
      bus.A = 1'b1; tick(1); bus.A = 1'b0;
      tick(5);
      bus.B = 1'b1; tick(1); bus.B = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b10) begin
         errors++; $display("FAIL to_b_edge6: got %b%b want 10", bus.modo_manual, bus.lampada);
      end
      for (int e = 1; e <= MANUAL_TIMEOUT; e++) begin
         logic want;
         tick(1);
         want = (e < MANUAL_TIMEOUT) ? 1'b1 : 1'b0;
         checks++;
         if (bus.modo_manual !== want) begin
            errors++; $display("FAIL to_after_b_edge_%0d: got %b want %b", e, bus.modo_manual, want);
         end
      end
      $display("txn manual_timeout: modo_manual=%b lampada=%b", bus.modo_manual, bus.lampada);
`else
      tick(100);
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b11) begin
         errors++; $display("FAIL no_timeout_100: got %b%b want 11", bus.modo_manual, bus.lampada);
      end
      bus.A = 1'b1; tick(1); bus.A = 1'b0;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b01) begin
         errors++; $display("FAIL no_timeout_exit: got %b%b want 01", bus.modo_manual, bus.lampada);
      end
      $display("txn manual_persist: modo_manual=%b lampada=%b", bus.modo_manual, bus.lampada);
`endif
   endtask

   task automatic test_reset_mid_hold();
      bus.presenca = 1'b1; tick(1);
      bus.presenca = 1'b0; tick(3);          // AUTO_HOLD, counter at 2
      checks++;
      if (bus.lampada !== 1'b1) begin
         errors++; $display("FAIL rmh_pre: got %b want 1", bus.lampada);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.modo_manual, bus.lampada} !== 2'b00) begin
         errors++; $display("FAIL rmh_async: got %b%b want 00", bus.modo_manual, bus.lampada);
      end
      tick(2);
      rst = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick(1);
         checks++;
         if ({bus.modo_manual, bus.lampada} !== 2'b00) begin
            errors++; $display("FAIL rmh_release_edge_%0d: got %b%b want 00", e, bus.modo_manual, bus.lampada);
         end
      end
      $display("txn reset_mid_hold: modo_manual=%b lampada=%b", bus.modo_manual, bus.lampada);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_hold_off();
      test_mode_switch();
      test_simultaneous();
      test_manual_timeout();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
